one_to_four_tdm_demux: RTL
==========================

# one_to_four_tdm_demux

Receive-side counterpart of the 4:1 mux path: the transmitter time-multiplexes four channels onto one serial lane, slot 0 through slot 3, and marks slot 0 with a frame-sync strobe. This block locks onto that sync, steers each incoming slot into its channel register, and presents all four channels as one parallel frame with a one-cycle valid pulse. It sits directly after the lane input and before any per-channel consumer logic.

## Interface
- DW, 1, data width of one slot/channel
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous, active-low reset
- inValid  input  1  lane sample present this cycle
- inSync  input  1  qualifies the current sample as slot 0; ignored unless inValid=1
- inData  input  DW  slot payload
- chOut  output  4*DW  frame; channel k at bits [k*DW +: DW]
- frameValid  output  1  one-cycle pulse: chOut holds a newly completed frame
- locked  output  1  block is in LOCKED state
- slotIdx  output  2  slot number expected for the next accepted sample
- syncErr  output  1  one-cycle pulse: sync seen mid-frame, partial frame discarded

## Operation
- States:
  - HUNT: the reset state.
  - LOCKED
- HUNT:
  - Samples with inSync=0 are ignored.
  - An accepted sample (inValid=1) with inSync=1 is written to slot 0. The block moves to LOCKED and slotIdx becomes 1.
- LOCKED:
  - Each accepted sample is written to the shadow register for slotIdx. slotIdx then increments mod 4.
  - When the slot-3 sample is accepted, the whole shadow frame is copied to chOut and frameValid pulses.
  - slotIdx wraps to 0. The block stays LOCKED.
- Sync with slotIdx=0 in LOCKED: normal frame start, no error.
- Sync with slotIdx≠0 in LOCKED:
  - The partial frame is discarded and syncErr pulses.
  - The current sample is taken as the new slot 0 and slotIdx becomes 1.
  - chOut is unchanged and frameValid stays 0.
- Sample with slotIdx=0, inSync=0 in LOCKED (missing sync):
  - Lock is lost: the block returns to HUNT, the sample is discarded and syncErr pulses.
- inValid=0: no state change. Gaps of any length are allowed between slots.
- chOut holds its value between frames. It changes only on the frameValid cycle.
- Reset values:
  - chOut = 0
  - frameValid = 0
  - locked = 0
  - slotIdx = 0
  - syncErr = 0
  - state = HUNT
  - shadow registers = 0

## Timing
- All outputs are registered.
- Latency: frameValid and the new chOut appear on the clock edge that samples the slot-3 input. They are visible in the cycle after the slot-3 input cycle.
- Back-to-back frames at full rate (inValid=1 continuously) give one frameValid every 4 cycles.
- locked rises on the edge that accepts the first sync. It falls on the edge that detects a missing sync.
- syncErr and frameValid are never asserted in the same cycle.
- rstN assertion mid-frame clears everything immediately, without waiting for a clock. The partial frame is lost. After release, the block hunts for sync again.
- There is no backpressure: consumers must take chOut during the frameValid cycle, or while chOut holds, before the next frame completes.

## Structure
- Shared package `tdm_pkg` holds:
  - NUM_SLOTS = 4 and SLOT_W = 2.
  - The state enum: HUNT, LOCKED.
  - These are reused by the transmit-side serializer.
- Sub-module `tdm_slot_counter`:
  - 2-bit counter with enable (inValid), synchronous load-to-1 (on sync) and clear.
  - Outputs slotIdx and a "last slot" flag.
  - The demux datapath and the FSM stay in the top module.

## Test plan
- Reset: hold rstN=0 for 3 cycles with random inputs. Required: chOut=0, frameValid=0, locked=0, slotIdx=0.
- Basic frame (DW=1):
  - Stimulus: inValid=1 continuously, data 1,0,1,1 with inSync on the first sample.
  - Required: frameValid pulses once after the 4th sample, chOut=4'b1101 (ch0 in the LSB), locked=1.
  - A second frame 0,1,0,0 follows immediately. Required: chOut=4'b0010 exactly 4 cycles later.
- Gaps:
  - Stimulus: the same frame with inValid=0 for 3 cycles between each slot.
  - Required: identical chOut=4'b1101, a single frameValid, and no change in slotIdx during the gaps.
- Early sync:
  - Stimulus: sync, 2 samples, then sync again with 1,1,1,1.
  - Required: syncErr pulses once, and the next frameValid shows chOut=4'b1111.
- Missing sync:
  - Stimulus: after a good frame, the next slot-0 sample arrives with inSync=0.
  - Required: syncErr pulses, locked=0, and no frameValid until a sync is followed by 4 samples.
- Reset mid-frame:
  - Stimulus: assert rstN=0 asynchronously after slot 1 of a frame.
  - Required: outputs clear immediately. After release, samples without sync produce no frameValid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM lane definitions: slot count, slot index width and lock-state encoding.
// Reused by both the transmit-side serializer and the receive-side demux.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;
endpackage

// File: rtl/one_to_four_tdm_demux_if.sv
// Serial lane in / parallel frame out bundle of the 1:4 TDM demux.
// The demux attaches through the slave modport.
interface one_to_four_tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int DW = 1
);
  logic                      inValid;
  logic                      inSync;
  logic [DW-1:0]             inData;
  logic [NUM_SLOTS*DW-1:0]   chOut;
  logic                      frameValid;
  logic                      locked;
  logic [SLOT_W-1:0]         slotIdx;
  logic                      syncErr;

  modport master (
    output inValid, inSync, inData,
    input  chOut, frameValid, locked, slotIdx, syncErr
  );

  modport slave (
    input  inValid, inSync, inData,
    output chOut, frameValid, locked, slotIdx, syncErr
  );
endinterface

// File: rtl/tdm_slot_counter.sv
// Slot position counter: counts accepted samples mod NUM_SLOTS, with load-to-1 on sync
// and clear on lock loss; clear wins over load, load wins over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              en_i,
  input  logic              load_i,
  input  logic              clr_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              last_o
);
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load_i) begin
      slot_d = SLOT_W'(1);
    end else if (en_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == SLOT_W'(NUM_SLOTS - 1));
endmodule

// File: rtl/one_to_four_tdm_demux.sv
// 1:4 TDM receive demux: locks onto the slot-0 sync strobe, collects four slots into
// shadow registers and publishes them as one parallel frame with a one-cycle valid.
module one_to_four_tdm_demux
  import tdm_pkg::*;
#(
  parameter int DW = 1
)(
  input  logic                     clk,
  input  logic                     rstN,
  one_to_four_tdm_demux_if.slave   bus
);
  tdm_state_e              state_q, state_d;
  logic [DW-1:0]           shadow_q [NUM_SLOTS];
  logic [NUM_SLOTS*DW-1:0] chOut_q, chOut_d;
  logic                    frameValid_q, syncErr_q;

  logic                    cnt_en, cnt_load, cnt_clr;
  logic [SLOT_W-1:0]       slot_idx;
  logic                    slot_last;
  logic                    wr_en, frame_done, err_d;
  logic [SLOT_W-1:0]       wr_slot;

  tdm_slot_counter u_slot_counter (
    .clk    (clk),
    .rstN   (rstN),
    .en_i   (cnt_en),
    .load_i (cnt_load),
    .clr_i  (cnt_clr),
    .slot_o (slot_idx),
    .last_o (slot_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_en     = 1'b0;
    cnt_load   = 1'b0;
    cnt_clr    = 1'b0;
    wr_en      = 1'b0;
    wr_slot    = slot_idx;
    frame_done = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        if (bus.inValid && bus.inSync) begin
          state_d  = LOCKED;
          cnt_load = 1'b1;
          wr_en    = 1'b1;
          wr_slot  = '0;
        end
      end
      LOCKED: begin
        if (bus.inValid) begin
          if (bus.inSync) begin
            // A sync always restarts the frame; mid-frame it also flags the discarded partial.
            cnt_load = 1'b1;
            wr_en    = 1'b1;
            wr_slot  = '0;
            err_d    = (slot_idx != '0);
          end else if (slot_idx == '0) begin
            state_d = HUNT;
            cnt_clr = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_en     = 1'b1;
            wr_en      = 1'b1;
            frame_done = slot_last;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // The slot-3 sample bypasses its shadow register so the frame lands on the same edge.
  always_comb begin
    chOut_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      chOut_d[k*DW +: DW] = (k == NUM_SLOTS - 1) ? bus.inData : shadow_q[k];
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= HUNT;
      chOut_q      <= '0;
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      frameValid_q <= frame_done;
      syncErr_q    <= err_d;
      if (wr_en) begin
        shadow_q[wr_slot] <= bus.inData;
      end
      if (frame_done) begin
        chOut_q <= chOut_d;
      end
    end
  end

  assign bus.chOut      = chOut_q;
  assign bus.frameValid = frameValid_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.slotIdx    = slot_idx;
  assign bus.syncErr    = syncErr_q;
endmodule
